dmem_resp: RTL and testbench



---
 rtl/dmem_pkg.sv | 48 ++++
 rtl/dmem_resp_tx_fifo.sv | 57 +++++
 rtl/dmem_resp.sv | 154 +++++++++++++++
 tb/tb_dmem_resp.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size encodings,
// MMIO register word offsets, STATUS bit positions and small decode helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  // MMIO register word offsets (byte offset >> 2) inside the 32-byte window
  localparam logic [2:0] OFF_TXDATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_CYCLE_LO = 3'd2;
  localparam logic [2:0] OFF_CYCLE_HI = 3'd3;
  localparam logic [2:0] OFF_HALT     = 3'd4;

  // STATUS register layout: [7:0] level, then flags
  localparam int STATUS_FULL_BIT  = 8;
  localparam int STATUS_EMPTY_BIT = 9;
  localparam int STATUS_OVF_BIT   = 10;

  // True when the size/alignment combination cannot be serviced
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replicates right-aligned store data across all byte lanes
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_resp_tx_fifo.sv
// Console transmit FIFO: 8-bit wide, power-of-two depth, push and pop may
// happen together (a push to a full FIFO succeeds if a pop frees a slot).
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_do_pop;
  logic w_do_push;

  assign o_level   = r_level;
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_head    = o_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: ;
      endcase
    end
  end

  // Storage; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: byte-lane data RAM with registered read-first
// output, plus an MMIO window holding the console FIFO, a 64-bit cycle
// counter with high-word shadow, and the halt/exit register.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wmask,
  input  logic        data_wen,
  input  logic [1:0]  data_size,
  output logic [31:0] data_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] exit_code,
  output logic        bus_err
);

  localparam int          RAM_AW    = $clog2(MEM_WORDS);
  localparam int          LVL_W     = $clog2(TX_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rdata;
  logic [63:0] r_cycle;
  logic [31:0] r_shadow;
  logic        r_ovf;
  logic        r_halt;
  logic [31:0] r_exit;
  logic        r_bus_err;

  logic              w_in_ram;
  logic              w_in_mmio;
  logic              w_err;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [2:0]        w_off;
  logic              w_ram_wr;
  logic              w_mmio_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_snap;
  logic [31:0]       w_wlanes;
  logic [31:0]       w_status;
  logic [31:0]       w_mmio_rd;
  logic [7:0]        w_head;
  logic [LVL_W-1:0]  w_level;
  logic              w_full;
  logic              w_empty;

  // Address decode and access classification
  assign w_in_ram  = (data_addr < RAM_BYTES);
  assign w_in_mmio = (data_addr[31:5] == MMIO_BASE[31:5]);
  assign w_err     = misaligned(data_size, data_addr[1:0]) || !(w_in_ram || w_in_mmio);
  assign w_ram_idx = data_addr[RAM_AW+1:2];
  assign w_off     = data_addr[4:2];
  assign w_wlanes  = lane_data(data_size, data_wdata);

  // A store asserted together with reset is discarded
  assign w_ram_wr  = data_wen && w_in_ram && !w_err && !rst;
  assign w_mmio_wr = data_wen && (data_wmask != 4'b0000) && w_in_mmio && !w_err;
  assign w_push    = w_mmio_wr && (w_off == OFF_TXDATA);
  assign w_pop     = tx_valid && tx_ready;
  assign w_snap    = w_in_mmio && !w_err && (w_off == OFF_CYCLE_LO);

  assign w_status  = {21'd0, r_ovf, w_empty, w_full, 8'(w_level)};

  assign data_rdata = r_rdata;
  assign tx_data    = w_head;
  assign tx_valid   = !w_empty;
  assign halt       = r_halt;
  assign exit_code  = r_exit;
  assign bus_err    = r_bus_err;

  tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (data_wdata[7:0]),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // MMIO read mux; TXDATA and reserved offsets read as zero
  always_comb begin
    w_mmio_rd = '0;
    case (w_off)
      OFF_STATUS:   w_mmio_rd = w_status;
      OFF_CYCLE_LO: w_mmio_rd = r_cycle[31:0];
      OFF_CYCLE_HI: w_mmio_rd = r_shadow;
      OFF_HALT:     w_mmio_rd = r_exit;
      default:      w_mmio_rd = '0;
    endcase
  end

  // Registered read path; RAM read happens before the same-edge write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_err) begin
      r_rdata <= '0;
    end else if (w_in_ram) begin
      r_rdata <= r_mem[w_ram_idx];
    end else if (w_in_mmio) begin
      r_rdata <= w_mmio_rd;
    end else begin
      r_rdata <= '0;
    end
  end

  // Byte-lane RAM write; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (data_wmask[k]) r_mem[w_ram_idx][8*k +: 8] <= w_wlanes[8*k +: 8];
      end
    end
  end

  // Counter, shadow, overflow flag, halt/exit and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle   <= '0;
      r_shadow  <= '0;
      r_ovf     <= 1'b0;
      r_halt    <= 1'b0;
      r_exit    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_cycle   <= r_cycle + 64'd1;
      r_bus_err <= w_err;
      if (w_snap) r_shadow <= r_cycle[63:32];
      if (w_mmio_wr && (w_off == OFF_STATUS)) r_ovf <= 1'b0;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_mmio_wr && (w_off == OFF_HALT)) begin
        r_halt <= 1'b1;
        r_exit <= data_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed scenarios followed by random traffic, all
// checked against a byte-addressed memory / queue model of the responder.
module tb_dmem_resp;
  import dmem_pkg::*;

  localparam int          MEM_WORDS  = 4096;
  localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;
  localparam int          TX_DEPTH   = 8;
  localparam int          TEST_WORDS = 128;
  localparam logic [31:0] RAM_BYTES  = 32'(4 * MEM_WORDS);

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wmask;
  logic        data_wen;
  logic [1:0]  data_size;
  logic [31:0] data_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;
  logic [31:0] exit_code;
  logic        bus_err;

  always #5 clk = ~clk;

  dmem_resp #(
    .MEM_WORDS (MEM_WORDS),
    .MMIO_BASE (MMIO_BASE),
    .TX_DEPTH  (TX_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_wmask (data_wmask),
    .data_wen   (data_wen),
    .data_size  (data_size),
    .data_rdata (data_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .halt       (halt),
    .exit_code  (exit_code),
    .bus_err    (bus_err)
  );

  // ---------------- reference model ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  m_mem [4*TEST_WORDS];
  bit          m_known [TEST_WORDS];
  logic [7:0]  m_q[$];
  bit          m_ovf;
  bit          m_halt;
  logic [31:0] m_exit;
  logic [63:0] m_cyc;
  logic [31:0] m_shadow;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
      $error("%s observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] sz);
    bit in_ram;
    bit in_io;
    in_ram = (a < RAM_BYTES);
    in_io  = (a >= MMIO_BASE) && (a < MMIO_BASE + 32'd32);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    if (sz == 2'b01 && a[0]) return 1'b1;
    return !(in_ram || in_io);
  endfunction

  // Byte that lands in lane k for a store of the given size
  function automatic logic [7:0] lane(input logic [1:0] sz, input logic [31:0] wd, input int k);
    if (sz == 2'b00) return wd[7:0];
    if (sz == 2'b01) return wd[8*(k%2) +: 8];
    return wd[8*k +: 8];
  endfunction

  // ---------------- driver: one bus cycle ----------------
  task automatic cyc(input logic [31:0] a, input logic [1:0] sz, input bit wen,
                     input logic [31:0] wd, input logic [3:0] wm, input bit rdy,
                     input string tag);
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic [7:0]  exp_pop;
    logic [7:0]  obs_pop;
    bit          exp_err;
    bit          rd_known;
    bit          pop;
    int          off;
    int          w;

    exp_err  = m_err(a, sz);
    exp_rd   = '0;
    rd_known = 1'b1;
    w        = int'(a >> 2);
    off      = int'((a - MMIO_BASE) >> 2);

    // expected load value from state before the edge
    if (!exp_err) begin
      if (a < RAM_BYTES) begin
        if (w < TEST_WORDS && m_known[w])
          exp_rd = {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
        else
          rd_known = 1'b0;
      end else begin
        case (off)
          1: exp_rd = {21'd0, m_ovf, (m_q.size() == 0), (m_q.size() == TX_DEPTH), 8'(m_q.size())};
          2: exp_rd = m_cyc[31:0];
          3: exp_rd = m_shadow;
          4: exp_rd = m_exit;
          default: exp_rd = '0;
        endcase
        if (off == 2) m_shadow = m_cyc[63:32];
      end
    end
    if (rd_known) exp_q.push_back(exp_rd);

    // consumer side
    pop = rdy && (m_q.size() > 0);
    exp_pop = 8'h00;
    if (pop) exp_pop = m_q.pop_front();

    // store side effects
    if (wen && !exp_err) begin
      if (a < RAM_BYTES) begin
        if (w < TEST_WORDS) begin
          for (int k = 0; k < 4; k++)
            if (wm[k]) m_mem[4*w+k] = lane(sz, wd, k);
          if (wm == 4'hF) m_known[w] = 1'b1;
        end
      end else if (wm != 4'b0000) begin
        case (off)
          0: if (m_q.size() < TX_DEPTH) m_q.push_back(wd[7:0]); else m_ovf = 1'b1;
          1: m_ovf = 1'b0;
          4: begin m_halt = 1'b1; m_exit = wd; end
          default: ;
        endcase
      end
    end

    data_addr  = a;
    data_size  = sz;
    data_wen   = wen;
    data_wdata = wd;
    data_wmask = wm;
    tx_ready   = rdy;
    #1;
    obs_pop = tx_data;
    @(posedge clk);
    #1;
    m_cyc = m_cyc + 64'd1;

    if (rd_known) begin
      got_rd = exp_q.pop_front();
      check($sformatf("%s.rdata", tag), data_rdata, got_rd);
    end
    if (pop) check($sformatf("%s.pop_byte", tag), {24'd0, obs_pop}, {24'd0, exp_pop});
    check($sformatf("%s.bus_err", tag), {31'd0, bus_err}, {31'd0, exp_err});
    check($sformatf("%s.tx_valid", tag), {31'd0, tx_valid}, {31'd0, (m_q.size() > 0)});
    check($sformatf("%s.tx_data", tag), {24'd0, tx_data},
          {24'd0, (m_q.size() > 0) ? m_q[0] : 8'h00});
    check($sformatf("%s.halt", tag), {31'd0, halt}, {31'd0, m_halt});
    check($sformatf("%s.exit_code", tag), exit_code, m_exit);
  endtask

  // Reset cycle, optionally with a store presented that must be discarded
  task automatic do_reset(input logic [31:0] a, input bit wen, input logic [31:0] wd);
    rst        = 1'b1;
    data_addr  = a;
    data_size  = 2'b10;
    data_wen   = wen;
    data_wdata = wd;
    data_wmask = 4'hF;
    tx_ready   = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    data_wen = 1'b0;
    data_addr = '0;
    m_q.delete();
    exp_q.delete();
    m_ovf    = 1'b0;
    m_halt   = 1'b0;
    m_exit   = '0;
    m_cyc    = '0;
    m_shadow = '0;
    check("reset.rdata", data_rdata, 32'h0);
    check("reset.tx_valid", {31'd0, tx_valid}, 32'h0);
    check("reset.tx_data", {24'd0, tx_data}, 32'h0);
    check("reset.halt", {31'd0, halt}, 32'h0);
    check("reset.exit_code", exit_code, 32'h0);
    check("reset.bus_err", {31'd0, bus_err}, 32'h0);
  endtask

  // ---------------- stimulus sequence ----------------
  logic [31:0] r_a;
  logic [31:0] r_wd;
  logic [1:0]  r_sz;
  logic [3:0]  r_wm;
  bit          r_wen;
  bit          r_rdy;
  int          r_kind;

  initial begin
    for (int i = 0; i < TEST_WORDS; i++) m_known[i] = 1'b0;
    do_reset(32'h0, 1'b0, 32'h0);

    // fill the modelled RAM region with known words
    for (int i = 0; i < TEST_WORDS; i++)
      cyc(32'(4*i), 2'b10, 1'b1, $urandom, 4'hF, 1'b0, "fill");

    // word store then sub-word loads of the same word, then byte store
    cyc(32'h100, 2'b10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, "sw");
    cyc(32'h101, 2'b00, 1'b0, 32'h0, 4'h0, 1'b0, "lb");
    check("lb.const", data_rdata, 32'hDEADBEEF);
    cyc(32'h102, 2'b01, 1'b0, 32'h0, 4'h0, 1'b0, "lh");
    check("lh.const", data_rdata, 32'hDEADBEEF);
    cyc(32'h100, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "lw");
    check("lw.const", data_rdata, 32'hDEADBEEF);
    cyc(32'h103, 2'b00, 1'b1, 32'h55, 4'b1000, 1'b0, "sb");
    cyc(32'h100, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "lw2");
    check("lw2.const", data_rdata, 32'h55ADBEEF);

    // nine pushes into an eight-deep FIFO with the consumer stalled
    for (int i = 0; i < 9; i++)
      cyc(MMIO_BASE, 2'b10, 1'b1, 32'(8'h41 + i), 4'hF, 1'b0, "push9");
    cyc(MMIO_BASE + 32'h4, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "status_ovf");
    check("status_ovf.const", data_rdata, 32'h0000_0508);
    for (int i = 0; i < 9; i++)
      cyc(32'h0, 2'b10, 1'b0, 32'h0, 4'h0, 1'b1, "drain9");
    cyc(MMIO_BASE + 32'h4, 2'b10, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, "ovf_clear");
    cyc(MMIO_BASE + 32'h4, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "status_empty");
    check("status_empty.const", data_rdata, 32'h0000_0200);

    // full FIFO: push and pop in the same cycle
    for (int i = 0; i < 8; i++)
      cyc(MMIO_BASE, 2'b10, 1'b1, 32'(8'h61 + i), 4'hF, 1'b0, "fill8");
    cyc(MMIO_BASE, 2'b10, 1'b1, 32'h5A, 4'hF, 1'b1, "push_pop_full");
    cyc(MMIO_BASE + 32'h4, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "status_full");
    check("status_full.const", data_rdata, 32'h0000_0108);
    for (int i = 0; i < 9; i++)
      cyc(32'h0, 2'b10, 1'b0, 32'h0, 4'h0, 1'b1, "drain8");

    // cycle counter: low read snapshots high, high returns snapshot
    for (int i = 0; i < 20; i++)
      cyc(32'h0, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "idle");
    cyc(MMIO_BASE + 32'h8, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "cyc_lo");
    cyc(MMIO_BASE + 32'hC, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "cyc_hi");
    cyc(MMIO_BASE + 32'h14, 2'b10, 1'b1, 32'h1234, 4'hF, 1'b0, "reserved");

    // erroneous accesses: no RAM change, zero read data, one-cycle pulse
    cyc(32'h102, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "err_lw_mis");
    cyc(32'h101, 2'b01, 1'b1, 32'hFFFF, 4'b0110, 1'b0, "err_sh_mis");
    cyc(32'h2000_0000, 2'b10, 1'b1, 32'h0, 4'hF, 1'b0, "err_range");
    cyc(32'h100, 2'b11, 1'b1, 32'h0, 4'hF, 1'b0, "err_size");
    cyc(32'h100, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "err_after");
    check("err_after.const", data_rdata, 32'h55ADBEEF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r_kind = $urandom_range(0, 99);
      r_rdy  = ($urandom_range(0, 1) == 1);
      r_wd   = $urandom;
      r_wen  = ($urandom_range(0, 1) == 1);
      if (r_kind < 60) begin
        r_a  = 32'($urandom_range(0, 4*TEST_WORDS-1));
        r_sz = 2'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) r_sz = 2'b11;
        if ($urandom_range(0, 4) != 0) begin
          if (r_sz == 2'b10) r_a[1:0] = 2'b00;
          if (r_sz == 2'b01) r_a[0] = 1'b0;
        end
        r_wm = (r_sz == 2'b00) ? (4'b0001 << r_a[1:0]) :
               (r_sz == 2'b01) ? (4'b0011 << r_a[1:0]) : 4'hF;
      end else if (r_kind < 92) begin
        r_a  = MMIO_BASE + 32'(4 * $urandom_range(0, 7));
        r_sz = 2'b10;
        r_wm = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'hF;
      end else begin
        r_a  = ($urandom_range(0, 1) == 1) ? RAM_BYTES + 32'($urandom_range(0, 255)) * 4
                                          : 32'h2000_0000 + 32'($urandom_range(0, 255)) * 4;
        r_sz = 2'b10;
        r_wm = 4'hF;
      end
      cyc(r_a, r_sz, r_wen, r_wd, r_wm, r_rdy, "rand");
    end

    // halt register, stores after halt, reset with a pending store
    cyc(MMIO_BASE + 32'h10, 2'b10, 1'b1, 32'h0000_002A, 4'hF, 1'b0, "halt_wr");
    check("halt_wr.halt_const", {31'd0, halt}, 32'h1);
    check("halt_wr.exit_const", exit_code, 32'd42);
    cyc(32'h104, 2'b10, 1'b1, 32'h1357_9BDF, 4'hF, 1'b0, "sw_after_halt");
    cyc(32'h104, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "lw_after_halt");
    check("lw_after_halt.const", data_rdata, 32'h1357_9BDF);
    do_reset(32'h104, 1'b1, 32'hCAFE_F00D);
    cyc(32'h104, 2'b10, 1'b0, 32'h0, 4'h0, 1'b0, "lw_after_rst");
    check("lw_after_rst.const", data_rdata, 32'h1357_9BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
